// File: rtl/spike_pkg.sv
// ---------------------------------------------------------------------------
// spike_pkg
// Shared constants and elaboration-time helpers for the spike MAC pipeline.
//   clog2        : ceiling log2, used for tree depth and counter width
//   sum_width    : width of the per-sample weighted sum (W + clog2(N))
//   level_ops    : operand count at a given adder-tree level
//   level_offset : bit offset of a tree level inside the flat tree bus
// ---------------------------------------------------------------------------
package spike_pkg;

    localparam int N_IN_DEFAULT      = 5;
    localparam int W_WIDTH_DEFAULT   = 16;
    localparam int ACC_WIDTH_DEFAULT = 32;
    localparam int T_STEPS_DEFAULT   = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    function automatic int sum_width(input int n_in, input int w_width);
        return w_width + clog2(n_in);
    endfunction

    // Each level halves the operand count, rounding up for an odd leftover.
    function automatic int level_ops(input int n_in, input int level);
        return (n_in + (1 << level) - 1) >> level;
    endfunction

    // All tree levels are packed back to back in one bus; level j operands
    // are (w_width + j) bits wide.
    function automatic int level_offset(input int n_in, input int w_width, input int level);
        int offset;
        offset = 0;
        for (int j = 0; j < level; j++) begin
            offset += level_ops(n_in, j) * (w_width + j);
        end
        return offset;
    endfunction

endpackage

// File: rtl/spike_add_stage.sv
// ---------------------------------------------------------------------------
// spike_add_stage
// One registered level of the signed adder tree. Operands are paired and
// summed with one bit of growth; an odd leftover is sign-extended and passed
// through without adding. Data only loads on valid cycles so bubbles leave
// the register untouched.
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : operands valid this cycle
//   in_data   : N_OPS signed operands of IN_W bits, operand i at [i*IN_W +: IN_W]
//   out_valid : registered valid
//   out_data  : ceil(N_OPS/2) signed results of IN_W+1 bits
// ---------------------------------------------------------------------------
module spike_add_stage
    import spike_pkg::*;
#(
    parameter int N_OPS = 2,
    parameter int IN_W  = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    input  logic [N_OPS*IN_W-1:0]                   in_data,
    output logic                                    out_valid,
    output logic [level_ops(N_OPS, 1)*(IN_W+1)-1:0] out_data
);

    localparam int N_OUT = level_ops(N_OPS, 1);
    localparam int OUT_W = IN_W + 1;

    logic [N_OUT*OUT_W-1:0] sum_w;
    logic [N_OUT*OUT_W-1:0] data_d;
    logic [N_OUT*OUT_W-1:0] data_q;
    logic                   valid_d;
    logic                   valid_q;

    for (genvar i = 0; i < N_OUT; i++) begin : g_pair
        logic [IN_W-1:0] op_a;
        assign op_a = in_data[2*i*IN_W +: IN_W];
        if (2*i + 1 < N_OPS) begin : g_add
            logic [IN_W-1:0] op_b;
            assign op_b = in_data[(2*i+1)*IN_W +: IN_W];
            assign sum_w[i*OUT_W +: OUT_W] = {op_a[IN_W-1], op_a} + {op_b[IN_W-1], op_b};
        end else begin : g_pass
            assign sum_w[i*OUT_W +: OUT_W] = {op_a[IN_W-1], op_a};
        end
    end

    always_comb begin
        data_d  = in_valid ? sum_w : data_q;
        valid_d = in_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/spike_mac_pipe.sv
// ---------------------------------------------------------------------------
// spike_mac_pipe
// Pipelined spike-gated multiply-accumulate. Stage 0 registers the gated
// weights, clog2(N_IN) registered tree levels reduce them to one signed sum,
// and a final stage accumulates the sum over a frame of T_STEPS samples with
// signed saturation. Latency from in_valid to out_valid is clog2(N_IN)+2.
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : spikes_in / weights_in / acc_clear valid this cycle
//   spikes_in   : one spike bit per channel
//   weights_in  : signed weight k at [k*W_WIDTH +: W_WIDTH]
//   acc_clear   : this sample opens a new frame
//   out_valid   : outputs below valid this cycle
//   sum_out     : signed per-sample weighted sum
//   acc_out     : signed frame accumulation including this sample
//   frame_last  : this sample closes the frame
//   sat_flag    : accumulator saturated somewhere in the current frame
// ---------------------------------------------------------------------------
module spike_mac_pipe
    import spike_pkg::*;
#(
    parameter int N_IN      = N_IN_DEFAULT,
    parameter int W_WIDTH   = W_WIDTH_DEFAULT,
    parameter int ACC_WIDTH = ACC_WIDTH_DEFAULT,
    parameter int T_STEPS   = T_STEPS_DEFAULT
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    input  logic [N_IN-1:0]                           spikes_in,
    input  logic [N_IN*W_WIDTH-1:0]                   weights_in,
    input  logic                                      acc_clear,
    output logic                                      out_valid,
    output logic signed [sum_width(N_IN, W_WIDTH)-1:0] sum_out,
    output logic signed [ACC_WIDTH-1:0]               acc_out,
    output logic                                      frame_last,
    output logic                                      sat_flag
);

    localparam int L          = clog2(N_IN);
    localparam int SUM_WIDTH  = sum_width(N_IN, W_WIDTH);
    localparam int SUM_OFFSET = level_offset(N_IN, W_WIDTH, L);
    localparam int TREE_BITS  = SUM_OFFSET + SUM_WIDTH;
    localparam int CNT_W      = clog2(T_STEPS + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(T_STEPS - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [N_IN*W_WIDTH-1:0] prod_d, prod_q;
    logic                    valid0_d, valid0_q;
    logic [L:0]              clr_d, clr_q;

    logic [TREE_BITS-1:0]    tree_data;
    logic [L:0]              tree_vld;
    logic [SUM_WIDTH-1:0]    tree_sum;

    logic [SUM_WIDTH-1:0]    sum_d, sum_q;
    logic [ACC_WIDTH-1:0]    acc_d, acc_q;
    logic [CNT_W-1:0]        cnt_d, cnt_q;
    logic                    last_d, last_q;
    logic                    sat_d, sat_q;
    logic                    out_valid_d, out_valid_q;

    logic [ACC_WIDTH:0]      sum_ext;
    logic [ACC_WIDTH:0]      acc_base;
    logic [ACC_WIDTH:0]      acc_raw;
    logic [CNT_W-1:0]        cnt_cur;
    logic                    opens;
    logic                    ovf;

    // Stage 0: gate each weight by its spike. acc_clear travels in a shift
    // register that lines up with the tree valid bits, so it reaches the
    // accumulator together with its own sample.
    always_comb begin
        prod_d = prod_q;
        if (in_valid) begin
            for (int k = 0; k < N_IN; k++) begin
                prod_d[k*W_WIDTH +: W_WIDTH] = spikes_in[k] ? weights_in[k*W_WIDTH +: W_WIDTH] : '0;
            end
        end
        valid0_d = in_valid;
        clr_d    = {clr_q[L-1:0], in_valid & acc_clear};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q   <= '0;
            valid0_q <= 1'b0;
            clr_q    <= '0;
        end else begin
            prod_q   <= prod_d;
            valid0_q <= valid0_d;
            clr_q    <= clr_d;
        end
    end

    assign tree_data[0 +: N_IN*W_WIDTH] = prod_q;
    assign tree_vld[0]                  = valid0_q;

    for (genvar l = 1; l <= L; l++) begin : g_level
        spike_add_stage #(
            .N_OPS (level_ops(N_IN, l-1)),
            .IN_W  (W_WIDTH + l - 1)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (tree_vld[l-1]),
            .in_data   (tree_data[level_offset(N_IN, W_WIDTH, l-1) +: level_ops(N_IN, l-1)*(W_WIDTH+l-1)]),
            .out_valid (tree_vld[l]),
            .out_data  (tree_data[level_offset(N_IN, W_WIDTH, l) +: level_ops(N_IN, l)*(W_WIDTH+l)])
        );
    end

    assign tree_sum = tree_data[SUM_OFFSET +: SUM_WIDTH];

    // Accumulator stage. cnt_q is the index the next sample would get, so it
    // reads zero exactly after reset or after a frame_last sample; either way
    // (or an explicit clear) the sample opens a frame. The add is done one
    // bit wider so overflow shows up as disagreement of the top two bits.
    always_comb begin
        sum_ext     = {{(ACC_WIDTH+1-SUM_WIDTH){tree_sum[SUM_WIDTH-1]}}, tree_sum};
        cnt_cur     = clr_q[L] ? '0 : cnt_q;
        opens       = clr_q[L] || (cnt_q == '0);
        acc_base    = opens ? '0 : {acc_q[ACC_WIDTH-1], acc_q};
        acc_raw     = sum_ext + acc_base;
        ovf         = acc_raw[ACC_WIDTH] != acc_raw[ACC_WIDTH-1];
        sum_d       = sum_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        sat_d       = sat_q;
        out_valid_d = tree_vld[L];
        if (tree_vld[L]) begin
            sum_d  = tree_sum;
            acc_d  = ovf ? (acc_raw[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : acc_raw[ACC_WIDTH-1:0];
            last_d = (cnt_cur == CNT_LAST);
            cnt_d  = last_d ? '0 : cnt_cur + CNT_W'(1);
            sat_d  = (opens ? 1'b0 : sat_q) | ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign sum_out    = sum_q;
    assign acc_out    = acc_q;
    assign frame_last = last_q;
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_spike_mac_pipe.sv
// ---------------------------------------------------------------------------
// tb_spike_mac_pipe
// Directed bench for spike_mac_pipe with N_IN=5, W_WIDTH=16, ACC_WIDTH=20,
// T_STEPS=4. Each issued sample pushes its hand-computed result and arrival
// cycle into a queue; a monitor on the falling edge pops and compares every
// out_valid beat, and checks that outputs hold while out_valid is low.
// ---------------------------------------------------------------------------
module tb_spike_mac_pipe;

    localparam int N_IN    = 5;
    localparam int W_WIDTH = 16;
    localparam int ACC_W   = 20;
    localparam int T_STEPS = 4;
    localparam int SUM_W   = 19;
    localparam int LATENCY = 5;

    typedef struct {
        int sum;
        int acc;
        int last;
        int sat;
        int cyc;
    } exp_t;

    logic                      clk;
    logic                      rst;
    logic                      in_valid;
    logic [N_IN-1:0]           spikes_in;
    logic [N_IN*W_WIDTH-1:0]   weights_in;
    logic                      acc_clear;
    logic                      out_valid;
    logic signed [SUM_W-1:0]   sum_out;
    logic signed [ACC_W-1:0]   acc_out;
    logic                      frame_last;
    logic                      sat_flag;

    exp_t sb_q[$];
    int   tests_run;
    int   tests_failed;
    int   cyc;
    int   outs_seen;
    int   hold_sum;
    int   hold_acc;
    int   hold_last;
    int   hold_sat;

    spike_mac_pipe #(
        .N_IN      (N_IN),
        .W_WIDTH   (W_WIDTH),
        .ACC_WIDTH (ACC_W),
        .T_STEPS   (T_STEPS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .spikes_in  (spikes_in),
        .weights_in (weights_in),
        .acc_clear  (acc_clear),
        .out_valid  (out_valid),
        .sum_out    (sum_out),
        .acc_out    (acc_out),
        .frame_last (frame_last),
        .sat_flag   (sat_flag)
    );

    // 10-unit clock and a free-running cycle counter for latency checks.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Watchdog so a wedged run still reports and terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one sample for one cycle; when expect_out is set, queue the
    // hand-computed result and the cycle it must appear on.
    task automatic applyStimulus(input logic [4:0] spk, input int w0, input int w1, input int w2,
                                 input int w3, input int w4, input logic clr, input int e_sum,
                                 input int e_acc, input int e_last, input int e_sat,
                                 input bit expect_out);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid   = 1'b1;
        spikes_in  = spk;
        weights_in = {16'(w4), 16'(w3), 16'(w2), 16'(w1), 16'(w0)};
        acc_clear  = clr;
        if (expect_out) begin
            e.sum  = e_sum;
            e.acc  = e_acc;
            e.last = e_last;
            e.sat  = e_sat;
            e.cyc  = cyc + LATENCY;
            sb_q.push_back(e);
        end
    endtask

    task automatic applyBubble();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        acc_clear = 1'b0;
        spikes_in = '1;
        weights_in = '1;
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        acc_clear = 1'b0;
        rst       = 1'b1;
        #2;
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_sum_out", int'(sum_out), 0);
        checkOutput("rst_acc_out", int'(acc_out), 0);
        checkOutput("rst_frame_last", int'(frame_last), 0);
        checkOutput("rst_sat_flag", int'(sat_flag), 0);
        repeat (2) @(posedge clk);
        hold_sum  = 0;
        hold_acc  = 0;
        hold_last = 0;
        hold_sat  = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
            @(negedge clk);
        end
        checkOutput("drain_queue_left", sb_q.size(), 0);
    endtask

    // Monitor: every out_valid beat must match the head of the scoreboard,
    // arrive on its scheduled cycle, and idle cycles must hold the last beat.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid) begin
                outs_seen++;
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_out_valid", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("latency_cycle", cyc, e.cyc);
                    checkOutput("sum_out", int'(sum_out), e.sum);
                    checkOutput("acc_out", int'(acc_out), e.acc);
                    checkOutput("frame_last", int'(frame_last), e.last);
                    checkOutput("sat_flag", int'(sat_flag), e.sat);
                    hold_sum  = e.sum;
                    hold_acc  = e.acc;
                    hold_last = e.last;
                    hold_sat  = e.sat;
                end
            end else begin
                checkOutput("hold_sum_out", int'(sum_out), hold_sum);
                checkOutput("hold_acc_out", int'(acc_out), hold_acc);
                checkOutput("hold_frame_last", int'(frame_last), hold_last);
                checkOutput("hold_sat_flag", int'(sat_flag), hold_sat);
            end
        end
    end

    initial begin
        int outs_before;
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        outs_seen    = 0;
        hold_sum     = 0;
        hold_acc     = 0;
        hold_last    = 0;
        hold_sat     = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        acc_clear    = 1'b0;
        spikes_in    = '0;
        weights_in   = '0;
        applyReset();

        // Single sample: channels 0,2,4 fire -> 100 + 7 - 50 = 57, opens frame.
        applyStimulus(5'b10101, 100, -3, 7, 2, -50, 1'b0, 57, 57, 0, 0, 1'b1);

        // Cleared frame of four unit samples, then the fifth opens a new frame.
        applyStimulus(5'b11111, 1, 1, 1, 1, 1, 1'b1, 5, 5, 0, 0, 1'b1);
        applyStimulus(5'b11111, 1, 1, 1, 1, 1, 1'b0, 5, 10, 0, 0, 1'b1);
        applyStimulus(5'b11111, 1, 1, 1, 1, 1, 1'b0, 5, 15, 0, 0, 1'b1);
        applyStimulus(5'b11111, 1, 1, 1, 1, 1, 1'b0, 5, 20, 1, 0, 1'b1);
        applyStimulus(5'b11111, 1, 1, 1, 1, 1, 1'b0, 5, 5, 0, 0, 1'b1);

        // Valid, bubble, valid: the bubble must not advance the frame.
        applyStimulus(5'b00011, 1, 1, 1, 1, 1, 1'b0, 2, 7, 0, 0, 1'b1);
        applyBubble();
        applyStimulus(5'b00011, 1, 1, 1, 1, 1, 1'b0, 2, 9, 0, 0, 1'b1);
        applyStimulus(5'b00001, -10, 1, 1, 1, 1, 1'b0, -10, -1, 1, 0, 1'b1);

        // Clear on the third sample restarts the count; frame_last 3 later.
        applyStimulus(5'b11111, 1, 2, 3, 4, 5, 1'b0, 15, 15, 0, 0, 1'b1);
        applyStimulus(5'b11111, 1, 2, 3, 4, 5, 1'b0, 15, 30, 0, 0, 1'b1);
        applyStimulus(5'b10000, 9, 9, 9, 9, -7, 1'b1, -7, -7, 0, 0, 1'b1);
        applyStimulus(5'b00001, 1, 0, 0, 0, 0, 1'b0, 1, -6, 0, 0, 1'b1);
        applyStimulus(5'b00001, 1, 0, 0, 0, 0, 1'b0, 1, -5, 0, 0, 1'b1);
        applyStimulus(5'b00001, 1, 0, 0, 0, 0, 1'b0, 1, -4, 1, 0, 1'b1);

        // Positive saturation at the 20-bit maximum, cleared by the next frame.
        applyStimulus(5'b11111, 32767, 32767, 32767, 32767, 32767, 1'b0, 163835, 163835, 0, 0, 1'b1);
        applyStimulus(5'b11111, 32767, 32767, 32767, 32767, 32767, 1'b0, 163835, 327670, 0, 0, 1'b1);
        applyStimulus(5'b11111, 32767, 32767, 32767, 32767, 32767, 1'b0, 163835, 491505, 0, 0, 1'b1);
        applyStimulus(5'b11111, 32767, 32767, 32767, 32767, 32767, 1'b0, 163835, 524287, 1, 1, 1'b1);
        applyStimulus(5'b00001, 3, 32767, 32767, 32767, 32767, 1'b0, 3, 3, 0, 0, 1'b1);

        // Negative saturation at the 20-bit minimum in a cleared frame.
        applyStimulus(5'b11111, -32768, -32768, -32768, -32768, -32768, 1'b1, -163840, -163840, 0, 0, 1'b1);
        applyStimulus(5'b11111, -32768, -32768, -32768, -32768, -32768, 1'b0, -163840, -327680, 0, 0, 1'b1);
        applyStimulus(5'b11111, -32768, -32768, -32768, -32768, -32768, 1'b0, -163840, -491520, 0, 0, 1'b1);
        applyStimulus(5'b11111, -32768, -32768, -32768, -32768, -32768, 1'b0, -163840, -524288, 1, 1, 1'b1);
        applyStimulus(5'b00001, 4, 0, 0, 0, 0, 1'b0, 4, 4, 0, 0, 1'b1);
        applyBubble();
        waitDrain();

        // Reset with three samples in flight: none may emerge afterwards,
        // and the next sample opens a fresh frame.
        applyStimulus(5'b11111, 7, 7, 7, 7, 7, 1'b0, 0, 0, 0, 0, 1'b0);
        applyStimulus(5'b11111, 7, 7, 7, 7, 7, 1'b0, 0, 0, 0, 0, 1'b0);
        applyStimulus(5'b11111, 7, 7, 7, 7, 7, 1'b0, 0, 0, 0, 0, 1'b0);
        applyReset();
        outs_before = outs_seen;
        repeat (10) @(posedge clk);
        checkOutput("flushed_outputs", outs_seen - outs_before, 0);
        applyStimulus(5'b00110, 0, 20, 30, 0, 0, 1'b0, 50, 50, 0, 0, 1'b1);
        applyStimulus(5'b00110, 0, 20, 30, 0, 0, 1'b0, 50, 100, 0, 0, 1'b1);
        applyBubble();
        waitDrain();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
